// File: rtl/seg_marquee.sv
// Scroll engine: holds the first 4-char window of a loaded text, then rotates the text left one char per step.
// Latency: char3..char0 update one cycle after an accept or a rotate step; wrap follows the final step by one cycle.
// Backpressure: load_ready is low only during the single LOAD cycle; otherwise new text is accepted in any state.
module seg_marquee #(
  parameter int NCHARS     = 16,
  parameter int STEP_DIV   = 256,
  parameter int HOLD_STEPS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [8*NCHARS-1:0] load_data,
  input  logic                clear,
  output logic [7:0]          char3,
  output logic [7:0]          char2,
  output logic [7:0]          char1,
  output logic [7:0]          char0,
  output logic                busy,
  output logic                wrap
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam int PW = $clog2(NCHARS + 1);
  localparam int BW = 8 * NCHARS;

  localparam logic [DW-1:0] DIV_MAX  = DW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_STEPS);
  localparam logic [PW-1:0] POS_END  = PW'(NCHARS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_SCROLL} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [31:0]     char_q, char_d;
  logic            wrap_q, wrap_d;

  logic            running;
  logic            accept;
  logic            step;
  logic [HW-1:0]   hold_inc;
  logic [PW-1:0]   pos_inc;
  logic            hold_done;
  logic            rev_done;

  // Qualify accept and step; clear blocks an accept, and an accept swallows a coincident step.
  always_comb begin
    running   = (state_q == S_HOLD) || (state_q == S_SCROLL);
    accept    = load_valid && (state_q != S_LOAD) && !clear;
    step      = running && tick && (div_q == DIV_MAX) && !clear && !accept;
    hold_inc  = hold_q + HW'(1);
    pos_inc   = pos_q + PW'(1);
    hold_done = (hold_inc == HOLD_END);
    rev_done  = (pos_inc == POS_END);
  end

  // Next-state logic for the IDLE/LOAD/HOLD/SCROLL controller.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:   state_d = (HOLD_STEPS == 0) ? S_SCROLL : S_HOLD;
        S_HOLD:   if (step && hold_done) state_d = S_SCROLL;
        S_SCROLL: if (step && rev_done) state_d = (HOLD_STEPS == 0) ? S_SCROLL : S_HOLD;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath next values: buffer rotate, tick divider, hold and position counters, wrap pulse.
  always_comb begin
    buf_d  = buf_q;
    div_d  = div_q;
    hold_d = hold_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (clear) begin
      buf_d  = '1;
      div_d  = '0;
      hold_d = '0;
      pos_d  = '0;
    end else if (accept) begin
      buf_d  = load_data;
      div_d  = '0;
      hold_d = '0;
      pos_d  = '0;
    end else if (running && tick) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
      if (step && state_q == S_HOLD) begin
        hold_d = hold_done ? '0 : hold_inc;
      end else if (step && state_q == S_SCROLL) begin
        // Leftmost char moves to the far right; the second char becomes leftmost.
        buf_d = {buf_q[BW-9:0], buf_q[BW-1 -: 8]};
        if (rev_done) begin
          pos_d  = '0;
          hold_d = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_inc;
        end
      end
    end
    char_d = buf_d[BW-1 -: 32];
  end

  // State and datapath registers; display taps track the buffer value being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '1;
      div_q   <= '0;
      hold_q  <= '0;
      pos_q   <= '0;
      char_q  <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      char_q  <= char_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    load_ready = (state_q != S_LOAD);
    busy       = (state_q == S_HOLD) || (state_q == S_SCROLL);
    wrap       = wrap_q;
    char3      = char_q[31:24];
    char2      = char_q[23:16];
    char1      = char_q[15:8];
    char0      = char_q[7:0];
  end

endmodule

// File: tb/tb_seg_marquee.sv
// Bench for seg_marquee: two instances (STEP_DIV=2/HOLD=3 and STEP_DIV=1/HOLD=0) share one stimulus stream.
// A text-plus-offset reference model predicts every output each cycle; directed phases add hand-derived checks.
// Inputs change and outputs are sampled on the falling edge.
module tb_seg_marquee;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, tick, load_valid, clear;
  logic [8*N-1:0] load_data;

  logic       a_rdy, a_busy, a_wrap, b_rdy, b_busy, b_wrap;
  logic [7:0] a_c3, a_c2, a_c1, a_c0, b_c3, b_c2, b_c1, b_c0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seg_marquee #(.NCHARS(N), .STEP_DIV(2), .HOLD_STEPS(3)) u_a (
    .clk(clk), .rst(rst), .tick(tick), .load_valid(load_valid), .load_ready(a_rdy),
    .load_data(load_data), .clear(clear), .char3(a_c3), .char2(a_c2), .char1(a_c1),
    .char0(a_c0), .busy(a_busy), .wrap(a_wrap));

  seg_marquee #(.NCHARS(N), .STEP_DIV(1), .HOLD_STEPS(0)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .load_valid(load_valid), .load_ready(b_rdy),
    .load_data(load_data), .clear(clear), .char3(b_c3), .char2(b_c2), .char1(b_c1),
    .char0(b_c0), .busy(b_busy), .wrap(b_wrap));

  wire [31:0] a_chars = {a_c3, a_c2, a_c1, a_c0};
  wire [31:0] b_chars = {b_c3, b_c2, b_c1, b_c0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the text as loaded plus how far the window has moved.
  // mode: 0 idle, 1 load, 2 hold, 3 scroll
  int         m_mode[2];
  logic [7:0] m_text[2][N];
  int         m_off[2];
  int         m_tcnt[2];
  int         m_hcnt[2];
  bit         m_wrap[2];

  function automatic int sd_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int hs_of(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  function automatic logic [31:0] m_chars(input int i);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[31-8*k -: 8] = m_text[i][(m_off[i] + k) % N];
    return r;
  endfunction

  task automatic m_blank(input int i);
    m_mode[i] = 0;
    for (int k = 0; k < N; k++) m_text[i][k] = 8'hFF;
    m_off[i]  = 0;
    m_tcnt[i] = 0;
    m_hcnt[i] = 0;
    m_wrap[i] = 1'b0;
  endtask

  task automatic m_edge(input int i);
    if (rst || clear) begin
      m_blank(i);
    end else if (load_valid && m_mode[i] != 1) begin
      for (int k = 0; k < N; k++) m_text[i][k] = load_data[8*(N-1-k) +: 8];
      m_off[i]  = 0;
      m_tcnt[i] = 0;
      m_hcnt[i] = 0;
      m_wrap[i] = 1'b0;
      m_mode[i] = 1;
    end else begin
      m_wrap[i] = 1'b0;
      if (m_mode[i] == 1) begin
        m_mode[i] = (hs_of(i) > 0) ? 2 : 3;
      end else if (m_mode[i] >= 2 && tick) begin
        m_tcnt[i]++;
        if (m_tcnt[i] == sd_of(i)) begin
          m_tcnt[i] = 0;
          if (m_mode[i] == 2) begin
            m_hcnt[i]++;
            if (m_hcnt[i] == hs_of(i)) m_mode[i] = 3;
          end else begin
            m_off[i]++;
            if (m_off[i] == N) begin
              m_off[i]  = 0;
              m_hcnt[i] = 0;
              m_wrap[i] = 1'b1;
              m_mode[i] = (hs_of(i) > 0) ? 2 : 3;
            end
          end
        end
      end
    end
  endtask

  initial begin
    m_blank(0);
    m_blank(1);
  end

  always @(posedge clk) begin
    m_edge(0);
    m_edge(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_chars", a_chars, m_chars(0));
      chk("a_ready", 32'(a_rdy), 32'(m_mode[0] != 1));
      chk("a_busy",  32'(a_busy), 32'(m_mode[0] >= 2));
      chk("a_wrap",  32'(a_wrap), 32'(m_wrap[0]));
      chk("b_chars", b_chars, m_chars(1));
      chk("b_ready", 32'(b_rdy), 32'(m_mode[1] != 1));
      chk("b_busy",  32'(b_busy), 32'(m_mode[1] >= 2));
      chk("b_wrap",  32'(b_wrap), 32'(m_wrap[1]));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [8*N-1:0] seq_data, a_data, c_data;

  initial begin
    rst = 1'b1; tick = 1'b0; load_valid = 1'b0; clear = 1'b0; load_data = '0;
    for (int k = 0; k < N; k++) begin
      seq_data[8*(N-1-k) +: 8] = 8'(k + 1);
      a_data[8*(N-1-k) +: 8]   = 8'(8'hA0 + k);
      c_data[8*(N-1-k) +: 8]   = 8'(8'hC0 + k);
    end

    // Reset held for two cycles, then idle ticks change nothing.
    cycles(2);
    chk_on = 1'b1;
    chk("rst_chars", a_chars, 32'hFFFF_FFFF);
    chk("rst_ready", 32'(a_rdy), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_wrap", 32'(a_wrap), 32'd0);
    rst = 1'b0;
    tick = 1'b1;
    cycles(100);
    chk("idle_chars", a_chars, 32'hFFFF_FFFF);
    chk("idle_busy", 32'(a_busy), 32'd0);

    // Load 01..10 with a tick every cycle.
    load_valid = 1'b1; load_data = seq_data;
    cycles(1);
    load_valid = 1'b0;
    chk("load_ready_low", 32'(a_rdy), 32'd0);
    cycles(1);
    chk("load_ready_back", 32'(a_rdy), 32'd1);
    chk("first_window", a_chars, 32'h0102_0304);
    cycles(6);
    chk("hold_end", a_chars, 32'h0102_0304);
    cycles(2);
    chk("first_rotate", a_chars, 32'h0203_0405);
    cycles(26);
    chk("pos14_window", a_chars, 32'h0F10_0102);
    cycles(3);
    chk("pos15_window", a_chars, 32'h1001_0203);
    chk("no_early_wrap", 32'(a_wrap), 32'd0);
    cycles(1);
    chk("wrap_restore", a_chars, 32'h0102_0304);
    chk("wrap_pulse", 32'(a_wrap), 32'd1);
    cycles(1);
    chk("wrap_one_cycle", 32'(a_wrap), 32'd0);

    // New text accepted on the same edge as a scroll step.
    cycles(10);
    chk("pre_accept", a_chars, 32'h0304_0506);
    load_valid = 1'b1; load_data = a_data;
    cycles(1);
    load_valid = 1'b0;
    chk("accept_wins", a_chars, 32'hA0A1_A2A3);
    cycles(8);
    chk("fresh_hold", a_chars, 32'hA0A1_A2A3);
    cycles(1);
    chk("fresh_rotate", a_chars, 32'hA1A2_A3A4);

    // Clear beats a simultaneous load.
    clear = 1'b1; load_valid = 1'b1; load_data = c_data;
    cycles(1);
    clear = 1'b0; load_valid = 1'b0;
    chk("clear_chars", a_chars, 32'hFFFF_FFFF);
    chk("clear_busy", 32'(a_busy), 32'd0);
    chk("clear_ready", 32'(a_rdy), 32'd1);
    cycles(5);
    chk("clear_stays", a_chars, 32'hFFFF_FFFF);

    // No-hold instance: rotate on the first tick after LOAD, reset mid-scroll, reload.
    load_valid = 1'b1; load_data = seq_data;
    cycles(1);
    load_valid = 1'b0;
    cycles(1);
    chk("b_first_window", b_chars, 32'h0102_0304);
    chk("b_busy_scroll", 32'(b_busy), 32'd1);
    cycles(1);
    chk("b_first_rotate", b_chars, 32'h0203_0405);
    cycles(4);
    chk("b_five_rotates", b_chars, 32'h0607_0809);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("b_rst_chars", b_chars, 32'hFFFF_FFFF);
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    load_valid = 1'b1; load_data = seq_data;
    cycles(1);
    load_valid = 1'b0;
    cycles(1);
    chk("b_reload", b_chars, 32'h0102_0304);
    cycles(1);
    chk("b_restart_pos0", b_chars, 32'h0203_0405);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 999) == 0);
      clear      = ($urandom_range(0, 299) == 0);
      load_valid = ($urandom_range(0, 119) == 0);
      tick       = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < N / 4; w++) load_data[32*w +: 32] = $urandom;
      cycles(1);
    end
    rst = 1'b0; clear = 1'b0; load_valid = 1'b0; tick = 1'b0;
    cycles(2);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
